// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared definitions for the register-file write-back queue.
//   REG_ADDR_W / REG_DATA_W : default register index / data widths
//   ZERO_REG                : hard-wired zero register, never written
//   wb_entry_t              : one queued write-back {valid, addr, data}
// Optional trace output in rf_wb_queue is enabled by defining RF_WB_TRACE_EN.
package rf_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/rf_wb_fifo.sv
// rf_wb_fifo: in-order circular buffer with up to two pushes and one pop per
// cycle, plus a per-entry address match vector for two forwarding queries.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   push0_i/_addr_i/_data_i       : first (older) entry to enqueue
//   push1_i/_addr_i/_data_i       : second entry; only used together with push0_i
//   pop_i                         : remove the head entry
//   head_valid_o/_addr_o/_data_o  : current head entry
//   count_o                       : number of valid entries (0..DEPTH)
//   rd_ptr_o                      : slot index of the head (oldest) entry
//   q_a1_i, q_a2_i                : forwarding query addresses
//   match1_o, match2_o            : per-slot "valid and addr equals query"
//   data_flat_o                   : all slot data, slot i at [i*DATA_W +: DATA_W]
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push0_i,
    input  logic [ADDR_W-1:0]             push0_addr_i,
    input  logic [DATA_W-1:0]             push0_data_i,
    input  logic                          push1_i,
    input  logic [ADDR_W-1:0]             push1_addr_i,
    input  logic [DATA_W-1:0]             push1_data_i,
    input  logic                          pop_i,
    output logic                          head_valid_o,
    output logic [ADDR_W-1:0]             head_addr_o,
    output logic [DATA_W-1:0]             head_data_o,
    output logic [$clog2(DEPTH):0]        count_o,
    output logic [$clog2(DEPTH)-1:0]      rd_ptr_o,
    input  logic [ADDR_W-1:0]             q_a1_i,
    input  logic [ADDR_W-1:0]             q_a2_i,
    output logic [DEPTH-1:0]              match1_o,
    output logic [DEPTH-1:0]              match2_o,
    output logic [DEPTH*DATA_W-1:0]       data_flat_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_nxt;
    logic [CNT_W-1:0]  count_q, count_d;

    assign wr_ptr_nxt = wr_ptr_q + PTR_W'(1);

    always_comb begin
        valid_d  = valid_q;
        addr_d   = addr_q;
        data_d   = data_q;
        rd_ptr_d = rd_ptr_q;
        // The pop clears its slot before the pushes are applied, so a push into
        // the slot being freed (full queue, push+pop) leaves it valid.
        if (pop_i) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PTR_W'(1);
        end
        if (push0_i) begin
            valid_d[wr_ptr_q] = 1'b1;
            addr_d[wr_ptr_q]  = push0_addr_i;
            data_d[wr_ptr_q]  = push0_data_i;
        end
        if (push1_i) begin
            valid_d[wr_ptr_nxt] = 1'b1;
            addr_d[wr_ptr_nxt]  = push1_addr_i;
            data_d[wr_ptr_nxt]  = push1_data_i;
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        count_d  = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_valid_o = valid_q[rd_ptr_q];
    assign head_addr_o  = addr_q[rd_ptr_q];
    assign head_data_o  = data_q[rd_ptr_q];
    assign count_o      = count_q;
    assign rd_ptr_o     = rd_ptr_q;

    always_comb begin
        match1_o    = '0;
        match2_o    = '0;
        data_flat_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match1_o[i] = valid_q[i] && (addr_q[i] == q_a1_i);
            match2_o[i] = valid_q[i] && (addr_q[i] == q_a2_i);
            data_flat_o[i*DATA_W +: DATA_W] = data_q[i];
        end
    end

endmodule

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: write-back initiator for the register-file write port.
// Merges ALU and load write-back requests into an in-order FIFO, drains one
// entry per cycle as RFWr/A3/WD, and forwards still-queued values to decode.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   alu_we/alu_addr/alu_data      : ALU write-back request (older of a pair)
//   mem_we/mem_addr/mem_data      : load write-back request
//   stall                         : producers must not push next cycle
//   ovf                           : sticky, set when a request was dropped
//   RFWr/A3/WD                    : register-file write (committed on negedge)
//   q_a1/q_a2                     : forwarding query addresses
//   q_hit1/q_data1, q_hit2/q_data2: youngest queued value for each query
// Define RF_WB_TRACE_EN for a simulation trace of writes and drops.
module rf_wb_queue
    import rf_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_we,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              stall,
    output logic              ovf,
    output logic              RFWr,
    output logic [ADDR_W-1:0] A3,
    output logic [DATA_W-1:0] WD,
    input  logic [ADDR_W-1:0] q_a1,
    input  logic [ADDR_W-1:0] q_a2,
    output logic              q_hit1,
    output logic [DATA_W-1:0] q_data1,
    output logic              q_hit2,
    output logic [DATA_W-1:0] q_data2
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int FREE_W = CNT_W + 1;

    logic                    alu_req, mem_req, alu_acc, mem_acc, drop;
    logic [FREE_W-1:0]       free_slots;
    logic                    push0, push1;
    logic [ADDR_W-1:0]       push0_addr;
    logic [DATA_W-1:0]       push0_data;
    logic                    head_valid;
    logic [ADDR_W-1:0]       head_addr;
    logic [DATA_W-1:0]       head_data;
    logic [CNT_W-1:0]        count;
    logic [PTR_W-1:0]        rd_ptr;
    logic [DEPTH-1:0]        match1, match2;
    logic [DEPTH*DATA_W-1:0] data_flat;
    logic                    ovf_q, ovf_d;

    // Writes to the zero register are filtered before they can take a slot.
    assign alu_req = alu_we && (alu_addr != ADDR_W'(ZERO_REG));
    assign mem_req = mem_we && (mem_addr != ADDR_W'(ZERO_REG));

    // Slots available this cycle include the one freed by the same-cycle pop.
    assign free_slots = FREE_W'(DEPTH) - FREE_W'(count) + FREE_W'(RFWr);
    assign alu_acc    = alu_req && (free_slots != '0);
    assign mem_acc    = mem_req && (free_slots > FREE_W'(alu_acc));
    assign drop       = (alu_req && !alu_acc) || (mem_req && !mem_acc);

    // Accepted entries are packed into slot order: ALU first when present.
    assign push0      = alu_acc || mem_acc;
    assign push1      = alu_acc && mem_acc;
    assign push0_addr = alu_acc ? alu_addr : mem_addr;
    assign push0_data = alu_acc ? alu_data : mem_data;

    rf_wb_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push0_i     (push0),
        .push0_addr_i(push0_addr),
        .push0_data_i(push0_data),
        .push1_i     (push1),
        .push1_addr_i(mem_addr),
        .push1_data_i(mem_data),
        .pop_i       (RFWr),
        .head_valid_o(head_valid),
        .head_addr_o (head_addr),
        .head_data_o (head_data),
        .count_o     (count),
        .rd_ptr_o    (rd_ptr),
        .q_a1_i      (q_a1),
        .q_a2_i      (q_a2),
        .match1_o    (match1),
        .match2_o    (match2),
        .data_flat_o (data_flat)
    );

    assign RFWr  = head_valid;
    assign A3    = head_valid ? head_addr : '0;
    assign WD    = head_valid ? head_data : '0;
    // Fewer than two free slots means a dual push next cycle might not fit.
    assign stall = (count >= CNT_W'(DEPTH - 1));

    assign ovf_d = ovf_q || drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

    // Walk slots from oldest to youngest so the last match is the youngest.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx     = '0;
        q_hit1  = 1'b0;
        q_data1 = '0;
        q_hit2  = 1'b0;
        q_data2 = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if (match1[idx] && (q_a1 != ADDR_W'(ZERO_REG))) begin
                q_hit1  = 1'b1;
                q_data1 = data_flat[idx*DATA_W +: DATA_W];
            end
            if (match2[idx] && (q_a2 != ADDR_W'(ZERO_REG))) begin
                q_hit2  = 1'b1;
                q_data2 = data_flat[idx*DATA_W +: DATA_W];
            end
        end
    end

`ifdef RF_WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!rst && RFWr) begin
            $display("WB A3=%2X WD=%8X cnt=%0d", A3, WD, count);
        end
        if (!rst && drop) begin
            $display("WB overflow drop alu_we=%0b mem_we=%0b cnt=%0d", alu_we, mem_we, count);
        end
    end
`else
    // Trace disabled: no simulation output, identical logic.
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: randomized and directed stimulus for rf_wb_queue, checked
// against a queue-based reference model of pending write-backs.
module tb_rf_wb_queue;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 5;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          alu_we, mem_we;
  logic [AW-1:0] alu_addr, mem_addr;
  logic [DW-1:0] alu_data, mem_data;
  logic          stall, ovf, RFWr;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD;
  logic [AW-1:0] q_a1, q_a2;
  logic          q_hit1, q_hit2;
  logic [DW-1:0] q_data1, q_data2;

  rf_wb_queue #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_addr(alu_addr), .alu_data(alu_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
    .stall(stall), .ovf(ovf),
    .RFWr(RFWr), .A3(A3), .WD(WD),
    .q_a1(q_a1), .q_a2(q_a2),
    .q_hit1(q_hit1), .q_data1(q_data1),
    .q_hit2(q_hit2), .q_data2(q_data2)
  );

  // ---------------- reference model ----------------
  // pend_q: entries the register file has not yet consumed, oldest first.
  // exp_q : expected register-file writes in order, consumed by the monitor.
  logic [AW+DW-1:0] pend_q[$];
  logic [AW+DW-1:0] exp_q[$];
  logic             ovf_m;

  int n_cmp = 0;
  int n_err = 0;

  task automatic compare(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      pend_q.delete();
      exp_q.delete();
      ovf_m = 1'b0;
    end else begin
      // head written this cycle leaves first, freeing its slot
      if (pend_q.size() > 0) void'(pend_q.pop_front());
      if (alu_we && alu_addr != 0) begin
        if (pend_q.size() < DEPTH) begin
          pend_q.push_back({alu_addr, alu_data});
          exp_q.push_back({alu_addr, alu_data});
        end else ovf_m = 1'b1;
      end
      if (mem_we && mem_addr != 0) begin
        if (pend_q.size() < DEPTH) begin
          pend_q.push_back({mem_addr, mem_data});
          exp_q.push_back({mem_addr, mem_data});
        end else ovf_m = 1'b1;
      end
    end
  end

  function automatic logic [DW:0] fwd(input logic [AW-1:0] a);
    logic [DW:0] r;
    r = '0;
    if (a != 0)
      foreach (pend_q[i])
        if (pend_q[i][AW+DW-1:DW] == a) r = {1'b1, pend_q[i][DW-1:0]};
    return r;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic [DW:0]      f1, f2;
      logic [AW+DW-1:0] e;
      compare("stall", DW'(stall), DW'((DEPTH - pend_q.size()) < 2));
      compare("ovf", DW'(ovf), DW'(ovf_m));
      compare("RFWr", DW'(RFWr), DW'(pend_q.size() > 0));
      if (RFWr) begin
        if (exp_q.size() == 0) begin
          compare("write_unexpected", DW'(RFWr), '0);
        end else begin
          e = exp_q.pop_front();
          compare("A3", DW'(A3), DW'(e[AW+DW-1:DW]));
          compare("WD", WD, e[DW-1:0]);
        end
      end else begin
        compare("A3_idle", DW'(A3), '0);
        compare("WD_idle", WD, '0);
      end
      f1 = fwd(q_a1);
      f2 = fwd(q_a2);
      compare("q_hit1", DW'(q_hit1), DW'(f1[DW]));
      compare("q_data1", q_data1, f1[DW-1:0]);
      compare("q_hit2", DW'(q_hit2), DW'(f2[DW]));
      compare("q_data2", q_data2, f2[DW-1:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                     input logic mw, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                     input logic [AW-1:0] qa1, input logic [AW-1:0] qa2);
    alu_we = aw; alu_addr = aa; alu_data = ad;
    mem_we = mw; mem_addr = ma; mem_data = md;
    q_a1 = qa1; q_a2 = qa2;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input logic [AW-1:0] qa1, input logic [AW-1:0] qa2);
    for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, '0, qa1, qa2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    alu_we = 0; alu_addr = '0; alu_data = '0;
    mem_we = 0; mem_addr = '0; mem_data = '0;
    q_a1 = '0; q_a2 = '0;
    @(posedge clk); #1;
    rst = 1'b0;

    // idle after reset, sweep every query address
    for (int i = 0; i < 32; i++) cyc(0, '0, '0, 0, '0, '0, AW'(i), AW'(31 - i));

    // single ALU write: visible on RFWr the following cycle
    cyc(1, 5'd5, 32'h1234_5678, 0, '0, '0, 5'd5, 5'd0);
    idle(3, 5'd5, 5'd6);

    // dual push to the same register: ALU drains first, mem is youngest
    cyc(1, 5'd3, 32'hA, 1, 5'd3, 32'hB, 5'd3, 5'd3);
    idle(3, 5'd3, 5'd4);

    // dual pushes ignoring stall until the mem entry overflows; ovf sticky
    for (int i = 0; i < 4; i++)
      cyc(1, AW'(2 * i + 1), 32'h100 + i, 1, AW'(2 * i + 2), 32'h200 + i, AW'(2 * i + 1), 5'd2);
    idle(8, 5'd7, 5'd8);

    // zero-register writes never enqueue or forward
    cyc(1, 5'd0, 32'hFFFF_FFFF, 1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    idle(2, 5'd0, 5'd1);

    // reset with three entries queued discards them
    cyc(1, 5'd9, 32'h900, 1, 5'd10, 32'hA00, 5'd9, 5'd10);
    cyc(1, 5'd11, 32'hB00, 1, 5'd12, 32'hC00, 5'd11, 5'd12);
    rst = 1'b1;
    idle(1, 5'd11, 5'd12);
    rst = 1'b0;
    idle(4, 5'd11, 5'd12);

    // randomized traffic, mostly honouring stall, occasional reset
    for (int n = 0; n < 800; n++) begin
      logic aw, mw;
      aw = 1'($urandom_range(0, 1));
      mw = 1'($urandom_range(0, 1));
      if (stall && $urandom_range(0, 9) != 0) begin
        aw = 0;
        mw = 0;
      end
      rst = ($urandom_range(0, 199) == 0);
      cyc(aw, AW'($urandom_range(0, 7)), $urandom,
          mw, AW'($urandom_range(0, 7)), $urandom,
          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
    end
    rst = 1'b0;
    idle(8, 5'd1, 5'd2);

    // ---------------- report ----------------
    if (exp_q.size() != 0) compare("writes_outstanding", DW'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_queue.md
Name: rf_wb_queue

Overview:
- Write-back side initiator for the 32x32 register file write port: it produces the RFWr / A3 / WD triple the register file consumes on its falling-edge write.
- Accepts write-back requests from two producers (ALU path, memory/load path) and buffers them in a small in-order FIFO.
- Drains at most one entry per cycle into the register file.
- Exposes a forwarding lookup so the decode stage can read values that are still queued.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- DATA_W, 32, register data width.
- ADDR_W, 5, register index width.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- alu_we  input  1  ALU write-back request valid.
- alu_addr  input  ADDR_W  ALU destination register.
- alu_data  input  DATA_W  ALU result.
- mem_we  input  1  load write-back request valid.
- mem_addr  input  ADDR_W  load destination register.
- mem_data  input  DATA_W  load data.
- stall  output  1  producers must not push next cycle.
- ovf  output  1  sticky overflow flag.
- RFWr  output  1  register-file write enable.
- A3  output  ADDR_W  register-file write address.
- WD  output  DATA_W  register-file write data.
- q_a1  input  ADDR_W  forwarding query, port 1.
- q_a2  input  ADDR_W  forwarding query, port 2.
- q_hit1  output  1  pending write exists for q_a1.
- q_data1  output  DATA_W  forwarded data for q_a1.
- q_hit2  output  1  pending write exists for q_a2.
- q_data2  output  DATA_W  forwarded data for q_a2.

Behaviour:
- Reset, at the first posedge with rst=1:
  - count=0, read and write pointers=0, all entry valid bits=0, ovf=0.
  - Consequently RFWr=0, A3=0, WD=0, stall=0, q_hit*=0, q_data*=0.
  - A reset mid-drain discards all queued entries. No RF write occurs in the cycle after reset.
- Push, sampled at posedge:
  - Each request with we=1 and addr!=0 is enqueued.
  - Requests to register 0 are silently dropped and never reach RFWr.
  - When both producers push in the same cycle, the ALU entry is enqueued first (older), then the mem entry.
- Drain:
  - Combinationally, RFWr = head valid, A3 = head addr, WD = head data; all are 0 when the queue is empty.
  - The head is popped at every posedge where RFWr=1. The register file commits that write on the preceding negedge.
  - Latency: a request present in cycle N appears on RFWr in cycle N+1. Throughput is one write per cycle.
- Count arithmetic:
  - count_next = count + pushes_accepted - pop.
  - A simultaneous push and pop with DEPTH entries held is legal; the pop frees a slot first.
- stall = (DEPTH - count) < 2, combinational from registered count. This guarantees two pushes always fit on the cycle after stall=0.
- Overflow:
  - A push that does not fit after the same-cycle pop is dropped and sets ovf.
  - Within a dual push, the ALU entry has priority.
  - ovf clears only on rst.
- Forwarding:
  - q_hitK = 1 when q_aK != 0 and any valid queued entry has addr == q_aK.
  - q_dataK = data of the youngest matching entry, else 0.
  - The lookup covers registered entries only. Same-cycle incoming requests are not forwarded; this is the pipeline's responsibility.
  - The head entry that is being written this cycle still forwards.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished by count, not by pointer equality.

Optional Feature:
- RF_WB_TRACE_EN defined: at every posedge with RFWr=1, $display "WB A3=%2X WD=%8X cnt=%0d". A separate $display fires on each overflow drop.
- RF_WB_TRACE_EN undefined: no simulation output; the synthesized logic is identical.

Decomposition:
- Shared package rf_wb_pkg:
  - REG_ADDR_W=5, REG_DATA_W=32.
  - wb_entry_t struct {valid, addr, data}.
  - ZERO_REG=0.
- Sub-module rf_wb_fifo: circular buffer with 2-push / 1-pop, count, and a per-entry match vector output.
- The top level handles push ordering, zero-register filtering, stall/ovf and youngest-match selection.

Test Plan:
- rst=1 one cycle, then idle -> RFWr=0, stall=0, ovf=0, q_hit1=0 for all q_a1.
- alu_we: addr=5, data=0x12345678 in cycle 1 -> RFWr=1, A3=5, WD=0x12345678 in cycle 2; queue empty in cycle 3.
- Dual push alu(3, 0xA), mem(3, 0xB) in one cycle -> drain order A3=3/WD=0xA, then A3=3/WD=0xB. In the cycle between, q_a1=3 gives q_hit1=1, q_data1=0xB.
- Dual pushes on consecutive cycles until stall=1 (DEPTH=4) -> stall asserts when count>=3. A forced extra dual push drops mem only, ovf=1 and sticky.
- alu_we: addr=0, data=0xFFFFFFFF -> no enqueue, RFWr stays 0; q_a1=0 gives q_hit1=0.
- Assert rst with 3 entries queued -> next cycle RFWr=0, count=0, no further writes.
